fetch_pc_ctrl: RTL

Fetch-stage sequencer that owns the fetch PC and issues dual-instruction fetch requests to the ICache. It drives the pair-valid mask consumed by the IF2/ID1 instruction buffer. It applies redirects from branch and exception flushes, with exceptions taking priority. It throttles fetch on buffer back-pressure (`o_is_full`) and holds the request stable across ICache misses.

---
 rtl/fetch_pc_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: owns the fetch PC, issues pair fetch requests, applies redirects, throttles on buffer full.
// Rev 1.0
`default_nettype none

module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_EX,
    input  logic [31:0] ex_target,
    input  logic        flush_BR,
    input  logic [31:0] br_target,
    input  logic        i_icache_ack,
    input  logic        i_stall_icache,
    input  logic        i_buf_full,
    output logic [31:0] o_fetch_pc,
    output logic        o_fetch_en,
    output logic [1:0]  o_pair_mask,
    output logic        o_resp_kill,
    output logic [1:0]  o_state
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] MISS = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;

    logic        redir;
    logic [31:0] redir_raw;
    logic [31:0] redir_pc;
    logic [31:0] seq_pc;
    logic        miss_exit;

    // Exception redirect outranks a branch redirect in the same cycle.
    assign redir     = flush_EX | flush_BR;
    assign redir_raw = flush_EX ? ex_target : br_target;
    assign redir_pc  = redir_raw & ~32'd3;
    assign seq_pc    = pc[2] ? (pc + 32'd4) : (pc + 32'd8);
    assign miss_exit = !i_stall_icache && i_icache_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (i_stall_icache) begin
                    state_nxt = MISS;
                    if (redir) begin
                        pend_valid_nxt = 1'b1;
                        pend_pc_nxt    = redir_pc;
                    end
                end else if (redir) begin
                    pc_nxt    = redir_pc;
                    state_nxt = i_buf_full ? HOLD : RUN;
                end else if (i_icache_ack) begin
                    pc_nxt    = seq_pc;
                    state_nxt = i_buf_full ? HOLD : RUN;
                end else if (i_buf_full) begin
                    state_nxt = HOLD;
                end
            end
            MISS: begin
                if (miss_exit) begin
                    // A redirect deferred during the miss takes precedence on exit.
                    if (pend_valid) begin
                        pc_nxt         = pend_pc;
                        pend_valid_nxt = 1'b0;
                    end else if (redir) begin
                        pc_nxt = redir_pc;
                    end else begin
                        pc_nxt = seq_pc;
                    end
                    state_nxt = i_buf_full ? HOLD : RUN;
                end else if (redir) begin
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = redir_pc;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_nxt = redir_pc;
                end
                if (!i_buf_full) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_comb begin
        o_fetch_en  = (state == RUN) || (state == MISS);
        o_pair_mask = o_fetch_en ? (pc[2] ? 2'b10 : 2'b11) : 2'b00;
        o_resp_kill = (state == MISS) && miss_exit && (pend_valid || redir);
    end

    assign o_fetch_pc = pc;
    assign o_state    = state;

endmodule

`default_nettype wire
